// File: rtl/computer_system_pio_pkg.sv
// Shared constants for the lightweight-bus PIO blocks: register offsets and
// edge-capture mode encodings, plus the edge-qualification helper.
package computer_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_ANY  = 2;

  // A debounced change qualifies when its direction matches the capture mode.
  function automatic logic edge_match(input int edge_type, input logic changed,
                                      input logic rose);
    case (edge_type)
      EDGE_RISE: return changed & rose;
      EDGE_ANY:  return changed;
      default:   return changed & ~rose;
    endcase
  endfunction

endpackage

// File: rtl/computer_system_debounce.sv
// One input bit: two-flop synchroniser, stability counter and debounced level.
// changed/rose are high during the cycle whose closing edge updates stable.
module computer_system_debounce
  import computer_system_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CNT = 50000,
  parameter int   CNT_W        = 16,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable,
  output logic changed,
  output logic rose
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  assign changed = (sync2 != stable) && (cnt == CNT_LAST);
  assign rose    = changed & sync2;

  // Any return to the stable level restarts the count, so glitches are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= IDLE_LEVEL;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (changed) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/computer_system_keys_in.sv
// Avalon-MM input PIO: debounced key/switch inputs, sticky edge capture with
// write-one-to-clear, and a maskable level interrupt.
module computer_system_keys_in
  import computer_system_pio_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int DEBOUNCE_CNT = 50000,
  parameter int CNT_W        = 16,
  parameter int EDGE_TYPE    = 0,
  parameter int IDLE_LEVEL   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] changed;
  logic [WIDTH-1:0] rose;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      read_next;
  logic             write_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    computer_system_debounce #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .CNT_W       (CNT_W),
      .IDLE_LEVEL  (IDLE_LEVEL != 0)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .stable (stable[i]),
      .changed(changed[i]),
      .rose   (rose[i])
    );
    assign hit[i] = edge_match(EDGE_TYPE, changed[i], rose[i]);
  end

  assign write_en     = chipselect & ~write_n;
  assign clear_bits   = (write_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (write_en && address == ADDR_IRQMASK) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // OR-ing the new hits after the clear makes a same-cycle set win over W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clear_bits) | hit;
    end
  end

  always_comb begin
    read_next = '0;
    case (address)
      ADDR_DATA:    read_next = 32'(stable);
      ADDR_IRQMASK: read_next = 32'(irq_mask);
      ADDR_EDGECAP: read_next = 32'(edge_capture);
      default:      read_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= read_next;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_computer_system_keys_in.sv
// Directed bench for computer_system_keys_in with DEBOUNCE_CNT=4; a second
// instance in any-edge mode shares the stimulus.
module tb_computer_system_keys_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] readdata_any;
  logic        irq_any;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  computer_system_keys_in #(
    .WIDTH(4), .DEBOUNCE_CNT(4), .CNT_W(16), .EDGE_TYPE(0), .IDLE_LEVEL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  computer_system_keys_in #(
    .WIDTH(4), .DEBOUNCE_CNT(4), .CNT_W(16), .EDGE_TYPE(2), .IDLE_LEVEL(1)
  ) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_any), .irq(irq_any)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic bus_read(input logic [1:0] addr);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick(1);
    chipselect = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    tick(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);

    // 1: reset values and one-cycle read latency
    reset_n = 1'b1;
    address = 2'd0;
    check("latency_before_edge", readdata, 32'h0);
    tick(1);
    check("latency_after_edge", readdata, 32'hF);
    bus_read(2'd2);
    check("reset_irqmask", readdata, 32'h0);
    bus_read(2'd3);
    check("reset_edgecap", readdata, 32'h0);
    check("reset_irq_after", {31'd0, irq}, 32'h0);

    // 2: falling step on bit0; stable flips on the 6th edge, readdata one edge later
    address = 2'd0;
    in_port = 4'hE;
    tick(6);
    check("step_data_edge6", readdata, 32'hF);
    tick(1);
    check("step_data_edge7", readdata, 32'hE);
    bus_read(2'd3);
    check("step_edgecap", readdata, 32'h1);
    check("step_irq_masked", {31'd0, irq}, 32'h0);

    // 3: mask enable, zero write, W1C
    bus_write(2'd2, 32'h1);
    check("mask_irq_on", {31'd0, irq}, 32'h1);
    bus_read(2'd2);
    check("mask_readback", readdata, 32'h1);
    bus_write(2'd3, 32'h0);
    check("w1c_zero_irq", {31'd0, irq}, 32'h1);
    bus_read(2'd3);
    check("w1c_zero_edgecap", readdata, 32'h1);
    bus_write(2'd3, 32'h1);
    check("w1c_irq_off", {31'd0, irq}, 32'h0);
    bus_read(2'd3);
    check("w1c_edgecap", readdata, 32'h0);

    // 4: 3-clock glitch rejected, 4-clock pulse accepted
    in_port = 4'hC;
    tick(3);
    in_port = 4'hE;
    tick(8);
    bus_read(2'd0);
    check("glitch3_data", readdata, 32'hE);
    bus_read(2'd3);
    check("glitch3_edgecap", readdata, 32'h0);
    in_port = 4'hC;
    tick(4);
    in_port = 4'hE;
    tick(12);
    bus_read(2'd0);
    check("pulse4_data", readdata, 32'hE);
    bus_read(2'd3);
    check("pulse4_edgecap", readdata, 32'h2);
    check("pulse4_irq_masked", {31'd0, irq}, 32'h0);

    // 5: rising release of bit0 ignored in falling mode, captured in any-edge mode
    bus_write(2'd3, 32'hF);
    in_port = 4'hF;
    tick(8);
    bus_read(2'd0);
    check("rise_data", readdata, 32'hF);
    bus_read(2'd3);
    check("rise_edgecap_fall_mode", readdata, 32'h0);
    check("rise_edgecap_any_mode", readdata_any, 32'h1);
    check("rise_irq_any_mode", {31'd0, irq_any}, 32'h1);

    // 6: W1C lands on the same edge that bit2's fall is accepted
    bus_write(2'd3, 32'hF);
    in_port = 4'hB;
    tick(5);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3);
    check("set_wins_edgecap", readdata, 32'h4);
    check("set_wins_edgecap_any", readdata_any, 32'h4);

    // reset part-way through bit3's debounce
    in_port = 4'h3;
    tick(3);
    reset_n = 1'b0;
    #1;
    check("midreset_readdata", readdata, 32'h0);
    check("midreset_irq", {31'd0, irq}, 32'h0);
    in_port = 4'hF;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    bus_read(2'd0);
    check("post_reset_data", readdata, 32'hF);
    bus_read(2'd3);
    check("post_reset_edgecap", readdata, 32'h0);
    check("post_reset_edgecap_any", readdata_any, 32'h0);
    bus_read(2'd2);
    check("post_reset_irqmask", readdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
